mmu09_clkgen: RTL and testbench

- Clock, reset and tick-interrupt front end for the MMU09 SBC, sitting directly upstream of mmu09_sbc.
- From a single 4x master clock it generates the 6809 quadrature Q and E clocks and a stretched, active-low CPU reset.
- It also produces a periodic tick interrupt request with acknowledge.
- Supports E-cycle stretching for slow peripherals.

---
 rtl/mmu09_clkgen.sv | 103 ++++++++++
 tb/tb_mmu09_clkgen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu09_clkgen.sv
// mmu09_clkgen: 6809 Q/E quadrature clock, stretched CPU reset and tick IRQ front end for the MMU09 SBC.
// Revision: 1.0
`default_nettype none

module mmu09_clkgen #(
  parameter int RESET_CYCLES = 16,
  parameter int TICK_DIV     = 452,
  parameter int MAX_STRETCH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stretch,
  input  logic       tick_en,
  input  logic       tick_ack,
  output logic       qclk,
  output logic       eclk,
  output logic       reset_n,
  output logic       irq_n,
  output logic       tick_ovr,
  output logic       e_fall,
  output logic [1:0] phase
);

  localparam logic [7:0]  RST_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  STR_MAX   = 4'(MAX_STRETCH);

  logic [7:0]  rst_cnt;
  logic [15:0] tick_cnt;
  logic [3:0]  str_cnt;
  logic        hold;
  logic        cycle_done;
  logic        tick_fire;

  // A phase-3 edge either holds E high (stretch) or completes the E cycle.
  always_comb begin
    hold       = (phase == 2'd3) && stretch && reset_n && (str_cnt < STR_MAX);
    cycle_done = (phase == 2'd3) && !hold;
    tick_fire  = cycle_done && reset_n && tick_en && (tick_cnt == TICK_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 2'd0;
      qclk     <= 1'b0;
      eclk     <= 1'b0;
      reset_n  <= 1'b0;
      irq_n    <= 1'b1;
      tick_ovr <= 1'b0;
      e_fall   <= 1'b0;
      rst_cnt  <= '0;
      tick_cnt <= '0;
      str_cnt  <= '0;
    end else begin
      case (phase)
        2'd0: begin qclk <= 1'b1; phase <= 2'd1; end
        2'd1: begin eclk <= 1'b1; phase <= 2'd2; end
        2'd2: begin qclk <= 1'b0; phase <= 2'd3; end
        default: begin
          if (!hold) begin
            eclk  <= 1'b0;
            phase <= 2'd0;
          end
        end
      endcase

      if (hold) begin
        str_cnt <= str_cnt + 4'd1;
      end else if (phase == 2'd3) begin
        str_cnt <= '0;
      end

      e_fall <= cycle_done;

      if (!reset_n) begin
        irq_n <= 1'b1;
        if (cycle_done) begin
          if (rst_cnt == RST_LAST) begin
            reset_n <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
      end else begin
        if (cycle_done && tick_en) begin
          tick_cnt <= (tick_cnt == TICK_LAST) ? 16'd0 : tick_cnt + 16'd1;
        end
        // A fire outranks a simultaneous acknowledge, which also absorbs the overrun.
        if (tick_fire) begin
          irq_n <= 1'b0;
          if (!irq_n && !tick_ack) begin
            tick_ovr <= 1'b1;
          end
        end else if (tick_ack) begin
          irq_n <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmu09_clkgen.sv
// tb_mmu09_clkgen: directed and randomized self-checking bench for mmu09_clkgen.
// Revision: 1.0
`default_nettype none

module tb_mmu09_clkgen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stretch = 1'b0;
  logic tick_en = 1'b0;
  logic tick_ack = 1'b0;

  logic       qclk_a, eclk_a, reset_n_a, irq_n_a, tick_ovr_a, e_fall_a;
  logic [1:0] phase_a;
  logic       qclk_b, eclk_b, reset_n_b, irq_n_b, tick_ovr_b, e_fall_b;
  logic [1:0] phase_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mmu09_clkgen #(.RESET_CYCLES(16), .TICK_DIV(4), .MAX_STRETCH(8)) u_a (
    .clk(clk), .reset(reset), .stretch(stretch), .tick_en(tick_en), .tick_ack(tick_ack),
    .qclk(qclk_a), .eclk(eclk_a), .reset_n(reset_n_a), .irq_n(irq_n_a),
    .tick_ovr(tick_ovr_a), .e_fall(e_fall_a), .phase(phase_a)
  );

  mmu09_clkgen #(.RESET_CYCLES(16), .TICK_DIV(2), .MAX_STRETCH(0)) u_b (
    .clk(clk), .reset(reset), .stretch(stretch), .tick_en(tick_en), .tick_ack(tick_ack),
    .qclk(qclk_b), .eclk(eclk_b), .reset_n(reset_n_b), .irq_n(irq_n_b),
    .tick_ovr(tick_ovr_b), .e_fall(e_fall_b), .phase(phase_b)
  );

  logic [7:0] act_a, act_b;
  assign act_a = {phase_a, qclk_a, eclk_a, reset_n_a, irq_n_a, tick_ovr_a, e_fall_a};
  assign act_b = {phase_b, qclk_b, eclk_b, reset_n_b, irq_n_b, tick_ovr_b, e_fall_b};

  localparam logic [7:0] RESET_VEC = 8'b00_0_0_0_1_0_0;

  // Reference model: position in the 4-slot E cycle plus plain event counters.
  int m_tdiv [2] = '{4, 2};
  int m_smax [2] = '{8, 0};
  int m_pos  [2] = '{0, 0};
  int m_sc   [2] = '{0, 0};
  int m_rc   [2] = '{0, 0};
  int m_tc   [2] = '{0, 0};
  bit m_rel  [2] = '{0, 0};
  bit m_irq  [2] = '{0, 0};
  bit m_ovr  [2] = '{0, 0};
  bit m_ef   [2] = '{0, 0};

  always @(posedge clk) begin
    bit h, d, f;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pos[i] = 0; m_sc[i] = 0; m_rc[i] = 0; m_tc[i] = 0;
        m_rel[i] = 0; m_irq[i] = 0; m_ovr[i] = 0; m_ef[i] = 0;
      end else begin
        h = (m_pos[i] == 3) && stretch && m_rel[i] && (m_sc[i] < m_smax[i]);
        d = (m_pos[i] == 3) && !h;
        f = 0;
        if (h) m_sc[i]++;
        else begin
          m_pos[i] = (m_pos[i] + 1) % 4;
          if (d) m_sc[i] = 0;
        end
        m_ef[i] = d;
        if (!m_rel[i]) begin
          m_irq[i] = 0;
          if (d) begin
            m_rc[i]++;
            if (m_rc[i] == 16) m_rel[i] = 1;
          end
        end else begin
          if (d && tick_en) begin
            m_tc[i]++;
            if (m_tc[i] == m_tdiv[i]) begin
              m_tc[i] = 0;
              f = 1;
            end
          end
          if (f) begin
            if (m_irq[i] && !tick_ack) m_ovr[i] = 1;
            m_irq[i] = 1;
          end else if (tick_ack) begin
            m_irq[i] = 0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_vec(int i);
    logic q, e;
    q = (m_pos[i] == 1) || (m_pos[i] == 2);
    e = (m_pos[i] >= 2);
    return {2'(m_pos[i]), q, e, m_rel[i], ~m_irq[i], m_ovr[i], m_ef[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_qef;
    reset = 1'b1; stretch = 1'b0; tick_en = 1'b0; tick_ack = 1'b0;
    repeat (5) step();
    checks++;
    if (act_a !== RESET_VEC) begin fails++; $display("FAIL reset_a: got %b expected %b", act_a, RESET_VEC); end
    checks++;
    if (act_b !== RESET_VEC) begin fails++; $display("FAIL reset_b: got %b expected %b", act_b, RESET_VEC); end
    reset = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      step();
      exp_qef = {(e % 4 == 1) || (e % 4 == 2), (e % 4 == 2) || (e % 4 == 3), (e % 4 == 0)};
      checks++;
      if ({qclk_a, eclk_a, e_fall_a} !== exp_qef) begin
        fails++; $display("FAIL release_clocks edge %0d: got q/e/ef=%b expected %b", e, {qclk_a, eclk_a, e_fall_a}, exp_qef);
      end
      checks++;
      if (reset_n_a !== (e == 64) || reset_n_b !== (e == 64)) begin
        fails++; $display("FAIL reset_n_release edge %0d: got a=%b b=%b expected %b", e, reset_n_a, reset_n_b, (e == 64));
      end
    end
  endtask

  task automatic test_stretch();
    int n, len, exp_len;
    stretch = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) stretch = 1'b0;
      exp_len = (c < 2) ? 10 : 2;
      n = 0;
      while (eclk_a !== 1'b1 && n < 20) begin step(); n++; end
      len = 0;
      while (eclk_a === 1'b1 && len < 30) begin step(); len++; end
      checks++;
      if (len != exp_len) begin fails++; $display("FAIL stretch_len cycle %0d: got %0d expected %0d", c, len, exp_len); end
    end
  endtask

  task automatic test_tick_period();
    int n, t;
    stretch = 1'b0;
    tick_en = 1'b1;
    for (int round = 0; round < 2; round++) begin
      n = 0; t = 0;
      while (n < 4 && t < 100) begin
        step(); t++;
        if (e_fall_a === 1'b1) begin
          n++;
          checks++;
          if (irq_n_a !== (n < 4)) begin fails++; $display("FAIL tick_period round %0d ecycle %0d: got irq_n=%b expected %b", round, n, irq_n_a, (n < 4)); end
        end
      end
      if (n < 4) begin checks++; fails++; $display("FAIL tick_period timeout: got %0d ecycles expected 4", n); end
      tick_ack = 1'b1; step(); tick_ack = 1'b0;
      checks++;
      if (irq_n_a !== 1'b1 || tick_ovr_a !== 1'b0) begin
        fails++; $display("FAIL tick_ack_clear: got irq_n=%b ovr=%b expected 1 0", irq_n_a, tick_ovr_a);
      end
    end
  endtask

  task automatic test_tick_ovr();
    int n, t;
    reset = 1'b1; step(); step(); reset = 1'b0;
    tick_en = 1'b1;
    t = 0;
    while (reset_n_b !== 1'b1 && t < 100) begin step(); t++; end
    checks++;
    if (reset_n_b !== 1'b1) begin fails++; $display("FAIL ovr_release: got reset_n=%b expected 1", reset_n_b); end
    n = 0; t = 0;
    while (n < 4 && t < 100) begin
      step(); t++;
      if (e_fall_b === 1'b1) begin
        n++;
        checks++;
        if (irq_n_b !== (n < 2) || tick_ovr_b !== (n >= 4)) begin
          fails++; $display("FAIL tick_ovr ecycle %0d: got irq_n=%b ovr=%b expected %b %b", n, irq_n_b, tick_ovr_b, (n < 2), (n >= 4));
        end
      end
    end
    tick_ack = 1'b1; step(); tick_ack = 1'b0;
    checks++;
    if (irq_n_b !== 1'b1 || tick_ovr_b !== 1'b1) begin
      fails++; $display("FAIL ovr_sticky: got irq_n=%b ovr=%b expected 1 1", irq_n_b, tick_ovr_b);
    end
  endtask

  task automatic test_ack_same_edge();
    int n, t;
    reset = 1'b1; step(); reset = 1'b0;
    stretch = 1'b0; tick_en = 1'b1;
    t = 0;
    while (reset_n_a !== 1'b1 && t < 100) begin step(); t++; end
    for (int round = 0; round < 3; round++) begin
      n = 0; t = 0;
      while (n < 3 && t < 100) begin step(); t++; if (e_fall_a === 1'b1) n++; end
      t = 0;
      while (phase_a !== 2'd3 && t < 10) begin step(); t++; end
      tick_ack = (round < 2);
      step();
      tick_ack = 1'b0;
      checks++;
      if (e_fall_a !== 1'b1 || irq_n_a !== 1'b0 || tick_ovr_a !== (round == 2)) begin
        fails++; $display("FAIL ack_same_edge round %0d: got ef=%b irq_n=%b ovr=%b expected 1 0 %b", round, e_fall_a, irq_n_a, tick_ovr_a, (round == 2));
      end
    end
  endtask

  task automatic test_reset_mid_stretch();
    int t, edges;
    stretch = 1'b1;
    t = 0;
    while (phase_a !== 2'd3 && t < 20) begin step(); t++; end
    repeat (3) step();
    checks++;
    if (phase_a !== 2'd3 || eclk_a !== 1'b1) begin
      fails++; $display("FAIL mid_stretch_hold: got phase=%0d eclk=%b expected 3 1", phase_a, eclk_a);
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (act_a !== RESET_VEC) begin fails++; $display("FAIL mid_stretch_reset: got %b expected %b", act_a, RESET_VEC); end
    edges = 0;
    while (reset_n_a !== 1'b1 && edges < 200) begin step(); edges++; end
    checks++;
    if (edges != 64) begin fails++; $display("FAIL rerelease_edges: got %0d expected 64", edges); end
    stretch = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    for (int c = 0; c < 4000; c++) begin
      stretch  = ($urandom_range(0, 9) < 4);
      tick_en  = ($urandom_range(0, 9) < 8);
      tick_ack = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 799) == 0);
      step();
      ea = exp_vec(0);
      eb = exp_vec(1);
      checks++;
      if (act_a !== ea) begin fails++; $display("FAIL random_a cycle %0d: got %b expected %b", c, act_a, ea); end
      checks++;
      if (act_b !== eb) begin fails++; $display("FAIL random_b cycle %0d: got %b expected %b", c, act_b, eb); end
    end
    reset = 1'b0; stretch = 1'b0; tick_en = 1'b0; tick_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stretch();
    test_tick_period();
    test_tick_ovr();
    test_ack_same_edge();
    test_reset_mid_stretch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
